// File: rtl/redmule_job_ctrl.sv
// RedMulE job controller: queues offloaded jobs and walks the head job through
// tiler configuration, weight preload and compute, with watchdog and abort.
module redmule_job_ctrl #(
  parameter int unsigned N_CORES   = 8,
  parameter int unsigned N_JOBS    = 4,
  parameter int unsigned ID_WIDTH  = 8,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic                             job_valid_i,
  output logic                             job_ready_o,
  input  logic [ID_WIDTH-1:0]              job_id_i,
  input  logic [$clog2(N_CORES)-1:0]       job_core_i,
  output logic                             cfg_start_o,
  input  logic                             cfg_valid_i,
  input  logic                             w_loaded_i,
  input  logic                             z_done_i,
  input  logic                             abort_i,
  input  logic [TIMEOUT_W-1:0]             timeout_i,
  output logic                             busy_o,
  output logic                             first_load_o,
  output logic                             flush_o,
  output logic                             sched_rst_o,
  output logic                             finished_o,
  output logic                             done_valid_o,
  output logic                             done_err_o,
  output logic [ID_WIDTH-1:0]              done_id_o,
  output logic [ID_WIDTH-1:0]              cur_id_o,
  output logic [$clog2(N_JOBS+1)-1:0]      pending_o,
  output logic [N_CORES-1:0][1:0]          evt_o
);

  localparam int unsigned CORE_W = $clog2(N_CORES);
  localparam int unsigned PTR_W  = $clog2(N_JOBS);
  localparam int unsigned CNT_W  = $clog2(N_JOBS + 1);

  typedef enum logic [2:0] {
    IDLE, CONFIG, STARTING, COMPUTING, FINISHED, ABORT
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  logic [ID_WIDTH-1:0]  id_mem_q   [N_JOBS];
  logic [CORE_W-1:0]    core_mem_q [N_JOBS];

  logic                 push, pop, active, timeout_hit, queue_full, queue_empty;
  logic [ID_WIDTH-1:0]  head_id;
  logic [CORE_W-1:0]    head_core;

  assign queue_full  = (count_q == CNT_W'(N_JOBS));
  assign queue_empty = (count_q == '0);
  // A push coinciding with clear is dropped so the queue really ends up empty.
  assign push        = job_valid_i && !queue_full && !clear_i;
  assign pop         = (state_q == FINISHED) || (state_q == ABORT);
  assign active      = state_q inside {CONFIG, STARTING, COMPUTING};
  assign timeout_hit = (timeout_i != '0) && (wdog_q == timeout_i);
  assign head_id     = id_mem_q[rd_ptr_q];
  assign head_core   = core_mem_q[rd_ptr_q];

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wdog_d   = wdog_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (active && (wdog_q != '1)) wdog_d = wdog_q + TIMEOUT_W'(1);

    // Within active states: abort beats the normal step, which beats timeout.
    unique case (state_q)
      IDLE: if (!queue_empty) begin
        state_d = CONFIG;
        wdog_d  = '0;
      end
      CONFIG: begin
        if (abort_i)          state_d = ABORT;
        else if (cfg_valid_i) state_d = STARTING;
        else if (timeout_hit) state_d = ABORT;
      end
      STARTING: begin
        if (abort_i)          state_d = ABORT;
        else if (w_loaded_i)  state_d = COMPUTING;
        else if (timeout_hit) state_d = ABORT;
      end
      COMPUTING: begin
        if (abort_i)          state_d = ABORT;
        else if (z_done_i)    state_d = FINISHED;
        else if (timeout_hit) state_d = ABORT;
      end
      FINISHED, ABORT: state_d = IDLE;
      default:         state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wdog_d   = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before this clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wdog_q   <= wdog_d;
    end
  end

  // NOTE: queue storage has no reset; entries are only read when count_q says
  // they are valid, so their power-up contents never reach an output.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem_q[wr_ptr_q]   <= job_id_i;
      core_mem_q[wr_ptr_q] <= job_core_i;
    end
  end

  assign job_ready_o  = !queue_full;
  assign pending_o    = count_q;
  assign busy_o       = (state_q != IDLE) || !queue_empty;
  assign cfg_start_o  = (state_q == IDLE) && !queue_empty;
  assign first_load_o = (state_q == STARTING);
  assign flush_o      = pop;
  assign sched_rst_o  = pop;
  assign finished_o   = (state_q == FINISHED);
  assign done_valid_o = pop;
  assign done_err_o   = (state_q == ABORT);
  assign done_id_o    = pop ? head_id : '0;
  assign cur_id_o     = queue_empty ? '0 : head_id;

  always_comb begin
    evt_o = '0;
    if (pop) evt_o[head_core] = {state_q == ABORT, state_q == FINISHED};
  end

endmodule

// File: tb/tb_redmule_job_ctrl.sv
// Scoreboard bench for redmule_job_ctrl: stimulus queues the expected retirement
// of each job, a monitor compares every done/error event against it.
module tb_redmule_job_ctrl;

  localparam int N_CORES   = 8;
  localparam int N_JOBS    = 4;
  localparam int ID_WIDTH  = 8;
  localparam int TIMEOUT_W = 16;
  localparam int CORE_W    = $clog2(N_CORES);
  localparam int CNT_W     = $clog2(N_JOBS + 1);

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b0;
  logic                     clear_i = 1'b0;
  logic                     job_valid_i = 1'b0;
  logic                     job_ready_o;
  logic [ID_WIDTH-1:0]      job_id_i = '0;
  logic [CORE_W-1:0]        job_core_i = '0;
  logic                     cfg_start_o;
  logic                     cfg_valid_i = 1'b0;
  logic                     w_loaded_i = 1'b0;
  logic                     z_done_i = 1'b0;
  logic                     abort_i = 1'b0;
  logic [TIMEOUT_W-1:0]     timeout_i = '0;
  logic                     busy_o, first_load_o, flush_o, sched_rst_o;
  logic                     finished_o, done_valid_o, done_err_o;
  logic [ID_WIDTH-1:0]      done_id_o, cur_id_o;
  logic [CNT_W-1:0]         pending_o;
  logic [N_CORES-1:0][1:0]  evt_o;

  redmule_job_ctrl #(
    .N_CORES(N_CORES), .N_JOBS(N_JOBS), .ID_WIDTH(ID_WIDTH), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_id_i(job_id_i), .job_core_i(job_core_i),
    .cfg_start_o(cfg_start_o), .cfg_valid_i(cfg_valid_i),
    .w_loaded_i(w_loaded_i), .z_done_i(z_done_i), .abort_i(abort_i),
    .timeout_i(timeout_i), .busy_o(busy_o), .first_load_o(first_load_o),
    .flush_o(flush_o), .sched_rst_o(sched_rst_o), .finished_o(finished_o),
    .done_valid_o(done_valid_o), .done_err_o(done_err_o),
    .done_id_o(done_id_o), .cur_id_o(cur_id_o),
    .pending_o(pending_o), .evt_o(evt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [ID_WIDTH-1:0] id;
    logic [CORE_W-1:0]   core;
    bit                  err;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got 0x%0h, expected no activity", name, act);
  endtask

  // Monitor: outputs are stable at the falling edge, inputs change there too.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_valid_o) begin
        if (exp_q.size() == 0) begin
          fail_unexpected("unexpected_retire", 32'(done_id_o));
        end else begin
          exp_t e;
          logic [2*N_CORES-1:0] exp_evt;
          e = exp_q.pop_front();
          exp_evt = '0;
          exp_evt[2*int'(e.core) + (e.err ? 1 : 0)] = 1'b1;
          check("retire_id", 32'(done_id_o), 32'(e.id));
          check("retire_evt", 32'(evt_o), 32'(exp_evt));
          check("retire_err", 32'(done_err_o), 32'(e.err));
          check("retire_finished", 32'(finished_o), 32'(!e.err));
          check("retire_flush", 32'({flush_o, sched_rst_o}), 32'h3);
        end
      end else if ((evt_o != '0) || (done_id_o != '0)) begin
        fail_unexpected("stray_event", 32'(evt_o));
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Assumes the queue has room; the push lands on the next rising edge.
  task automatic push_job(input logic [ID_WIDTH-1:0] id, input logic [CORE_W-1:0] core,
                          input bit err);
    job_valid_i = 1'b1;
    job_id_i    = id;
    job_core_i  = core;
    exp_q.push_back('{id: id, core: core, err: err});
    tick();
    job_valid_i = 1'b0;
  endtask

  // Called at the falling edge of the first CONFIG cycle; returns in FINISHED.
  task automatic run_from_config(input int cfg_d, input int w_d, input int z_d);
    repeat (cfg_d) tick();
    cfg_valid_i = 1'b1; tick(); cfg_valid_i = 1'b0;
    check("first_load_in_starting", 32'(first_load_o), 32'h1);
    repeat (w_d) tick();
    w_loaded_i = 1'b1; tick(); w_loaded_i = 1'b0;
    check("first_load_off_computing", 32'(first_load_o), 32'h0);
    repeat (z_d) tick();
    z_done_i = 1'b1; tick(); z_done_i = 1'b0;
    check("finished_pulse", 32'(finished_o), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 rst_i = 1'b1;
    #11;
    check("rst_ready", 32'(job_ready_o), 32'h1);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_pending", 32'(pending_o), 32'h0);
    check("rst_evt", 32'(evt_o), 32'h0);
    check("rst_outs", 32'({cfg_start_o, first_load_o, flush_o, done_valid_o, cur_id_o}), 32'h0);
    tick();
    rst_i = 1'b0;
    tick();

    // Single job
    push_job(8'h11, 3'd3, 1'b0);
    check("t1_pending", 32'(pending_o), 32'h1);
    check("t1_cfg_start", 32'(cfg_start_o), 32'h1);
    check("t1_cur_id", 32'(cur_id_o), 32'h11);
    tick();
    check("t1_cfg_start_one_cycle", 32'(cfg_start_o), 32'h0);
    check("t1_no_first_load_config", 32'(first_load_o), 32'h0);
    run_from_config(1, 2, 4);
    tick();
    check("t1_busy_falls", 32'(busy_o), 32'h0);
    check("t1_cur_id_cleared", 32'(cur_id_o), 32'h0);

    // Queue full, in-order retirement, inter-job gap
    push_job(8'h21, 3'd0, 1'b0);
    tick();
    push_job(8'h22, 3'd1, 1'b0);
    push_job(8'h23, 3'd2, 1'b0);
    push_job(8'h24, 3'd4, 1'b0);
    check("t2_pending_full", 32'(pending_o), 32'h4);
    check("t2_ready_low", 32'(job_ready_o), 32'h0);
    job_valid_i = 1'b1; job_id_i = 8'h25; job_core_i = 3'd7;
    exp_q.push_back('{id: 8'h25, core: 3'd7, err: 1'b0});
    run_from_config(0, 1, 1);
    check("t2_fifth_held", 32'(pending_o), 32'h4);
    tick();
    check("t2_gap_idle_start", 32'(cfg_start_o), 32'h1);
    check("t2_pending_after_pop", 32'(pending_o), 32'h3);
    check("t2_ready_after_pop", 32'(job_ready_o), 32'h1);
    tick();
    job_valid_i = 1'b0;
    check("t2_fifth_accepted", 32'(pending_o), 32'h4);
    check("t2_cur_id_next", 32'(cur_id_o), 32'h22);
    run_from_config(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_gap_idle_start", 32'(cfg_start_o), 32'h1);
      tick();
      run_from_config(0, 0, 0);
    end
    tick();
    check("t2_drained", 32'(busy_o), 32'h0);

    // Watchdog: ABORT 21 cycles after CONFIG entry with timeout 20
    timeout_i = 16'd20;
    push_job(8'h31, 3'd5, 1'b1);
    push_job(8'h32, 3'd2, 1'b0);
    cfg_valid_i = 1'b1; tick(); cfg_valid_i = 1'b0;
    repeat (19) tick();
    check("t3_no_abort_at_T", 32'(done_valid_o), 32'h0);
    tick();
    check("t3_abort_at_T_plus_1", 32'({done_valid_o, done_err_o, finished_o}), 32'h6);
    timeout_i = '0;
    tick();
    check("t3_queue_advances", 32'({cfg_start_o, cur_id_o}), 32'h132);
    tick();
    run_from_config(0, 0, 0);
    tick();

    // Priority (a): z_done in the cycle the timeout fires
    timeout_i = 16'd5;
    push_job(8'h41, 3'd1, 1'b0);
    tick();
    cfg_valid_i = 1'b1; tick(); cfg_valid_i = 1'b0;
    w_loaded_i = 1'b1;  tick(); w_loaded_i = 1'b0;
    repeat (3) tick();
    z_done_i = 1'b1; tick(); z_done_i = 1'b0;
    check("t4a_finished_wins", 32'({finished_o, done_err_o}), 32'h2);
    timeout_i = '0;
    tick();

    // Priority (b): abort together with z_done
    push_job(8'h42, 3'd6, 1'b1);
    tick();
    cfg_valid_i = 1'b1; tick(); cfg_valid_i = 1'b0;
    w_loaded_i = 1'b1;  tick(); w_loaded_i = 1'b0;
    z_done_i = 1'b1; abort_i = 1'b1; tick(); z_done_i = 1'b0; abort_i = 1'b0;
    check("t4b_abort_wins", 32'({finished_o, done_err_o}), 32'h1);
    tick();

    // Priority (c): abort while idle is ignored
    abort_i = 1'b1;
    repeat (3) tick();
    check("t4c_idle_abort_ignored", 32'({busy_o, pending_o}), 32'h0);
    abort_i = 1'b0;
    push_job(8'h43, 3'd7, 1'b0);
    tick();
    run_from_config(0, 0, 0);
    tick();

    // Clear in COMPUTING with 3 pending plus a simultaneous push
    push_job(8'h51, 3'd0, 1'b0);
    push_job(8'h52, 3'd1, 1'b0);
    push_job(8'h53, 3'd2, 1'b0);
    cfg_valid_i = 1'b1; tick(); cfg_valid_i = 1'b0;
    w_loaded_i = 1'b1;  tick(); w_loaded_i = 1'b0;
    check("t5_pending_before", 32'(pending_o), 32'h3);
    clear_i = 1'b1; job_valid_i = 1'b1; job_id_i = 8'h54; job_core_i = 3'd1;
    exp_q.delete();
    tick();
    clear_i = 1'b0; job_valid_i = 1'b0;
    check("t5_pending_cleared", 32'(pending_o), 32'h0);
    check("t5_busy_cleared", 32'(busy_o), 32'h0);
    check("t5_no_start", 32'({cfg_start_o, cur_id_o}), 32'h0);
    tick();
    check("t5_push_dropped", 32'({busy_o, cfg_start_o, pending_o}), 32'h0);

    // Asynchronous reset mid-STARTING
    push_job(8'h61, 3'd2, 1'b0);
    tick();
    cfg_valid_i = 1'b1; tick(); cfg_valid_i = 1'b0;
    check("t6_in_starting", 32'(first_load_o), 32'h1);
    #2 rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("t6_rst_first_load", 32'(first_load_o), 32'h0);
    check("t6_rst_state", 32'({busy_o, pending_o, cur_id_o}), 32'h0);
    check("t6_rst_ready", 32'(job_ready_o), 32'h1);
    tick();
    rst_i = 1'b0;
    tick();
    check("t6_ready_after_release", 32'(job_ready_o), 32'h1);
    check("t6_idle_after_release", 32'({busy_o, cfg_start_o}), 32'h0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/redmule_job_ctrl.md
# redmule_job_ctrl

Parametrised job controller for the RedMulE accelerator. It queues up to N_JOBS offloaded jobs and sequences each one through configuration (tiler), weight preload and compute. Each job completes with a per-core done or error event. It sits between the peripheral slave job interface and the tiler/scheduler/engine. Over a single-job controller it adds a job queue, a watchdog timeout, an external abort, per-job ID tracking, and a busy flag that is correct by construction.

## Interface
- N_CORES, 8, number of cores receiving events
- N_JOBS, 4, job queue depth; power of two, ≥2
- ID_WIDTH, 8, job ID width
- TIMEOUT_W, 16, watchdog counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- clear_i  in  1  synchronous soft clear
- job_valid_i  in  1  job push request
- job_ready_o  out  1  queue can accept a job (not full)
- job_id_i  in  ID_WIDTH  ID of pushed job
- job_core_i  in  $clog2(N_CORES)  core to notify on completion
- cfg_start_o  out  1  tiler start pulse for head job
- cfg_valid_i  in  1  tiler configuration complete
- w_loaded_i  in  1  weights preloaded
- z_done_i  in  1  Z stream sink done
- abort_i  in  1  abort active job
- timeout_i  in  TIMEOUT_W  watchdog limit; 0 disables
- busy_o  out  1  active job or queued jobs present
- first_load_o  out  1  scheduler first-load phase
- flush_o  out  1  engine flush
- sched_rst_o  out  1  scheduler reset
- finished_o  out  1  normal completion pulse
- done_valid_o  out  1  job retired (normal or error)
- done_err_o  out  1  retired job was aborted or timed out
- done_id_o  out  ID_WIDTH  ID of retired job
- cur_id_o  out  ID_WIDTH  ID of head job
- pending_o  out  $clog2(N_JOBS+1)  queued jobs, active job included
- evt_o  out  [N_CORES-1:0][1:0]  per-core events: bit0 done, bit1 error

## Operation
- Queue: circular FIFO of {id, core}.
  - Push when job_valid_i && job_ready_o.
  - job_ready_o = pending_o != N_JOBS. No bypass when full.
  - Head is the active job. It is popped only in FINISHED or ABORT.
  - A push and a pop in the same cycle leave pending_o unchanged.
- FSM states: IDLE, CONFIG, STARTING, COMPUTING, FINISHED, ABORT.
  - IDLE: if pending_o != 0, assert cfg_start_o (combinational) and go to CONFIG.
  - CONFIG: on cfg_valid_i, go to STARTING.
  - STARTING: first_load_o=1. On w_loaded_i, go to COMPUTING.
  - COMPUTING: on z_done_i, go to FINISHED.
  - FINISHED (1 cycle): flush_o=1, sched_rst_o=1, finished_o=1, done_valid_o=1, done_err_o=0, evt_o[core][0]=1. Pop head, then go to IDLE.
  - ABORT (1 cycle): flush_o=1, sched_rst_o=1, finished_o=0, done_valid_o=1, done_err_o=1, evt_o[core][1]=1. Pop head, then go to IDLE.
- done_id_o equals the head ID during FINISHED/ABORT and is 0 otherwise.
- cur_id_o equals the head ID whenever pending_o != 0 and is 0 otherwise.
- Watchdog:
  - Counter is set to 0 on entry to CONFIG.
  - It increments every cycle in CONFIG/STARTING/COMPUTING and saturates at all-ones.
  - Timeout fires when counter == timeout_i and timeout_i != 0.
- Transition priority in active states: clear_i > abort_i > normal transition > timeout.
  - Example: z_done_i and timeout in the same cycle go to FINISHED.
  - abort_i in IDLE, FINISHED or ABORT is ignored.
- busy_o = (state != IDLE) || (pending_o != 0).
- clear_i (sync), effective next cycle:
  - state goes to IDLE, queue is emptied, counter goes to 0;
  - no event is produced;
  - a push in the same cycle is discarded.

## Timing
- Reset values:
  - state IDLE; all outputs 0 except job_ready_o=1;
  - pending_o=0, evt_o all 0.
- All outputs are combinational from registered state and queue except cfg_start_o, which also depends on pending_o, itself registered.
- Push-to-start: job pushed in cycle t into an empty, idle controller.
  - pending_o=1 and cfg_start_o=1 at t+1.
  - CONFIG at t+2.
- Back-to-back jobs: FINISHED at cycle f, IDLE at f+1 with cfg_start_o=1 if pending_o != 0, CONFIG at f+2. Minimum of 2 cycles between jobs.
- Events are single-cycle pulses. Exactly one evt_o bit is set per retired job; all other bits are 0.
- Timeout window: with timeout_i = T, a job that has not completed enters ABORT after T+1 active cycles, counted from the first CONFIG cycle.
- timeout_i is sampled every cycle. Changing it mid-job takes effect immediately.
- Reset mid-operation: asynchronous return to reset values. No event is produced.

## Test plan
- Single job:
  - stimulus: push id=0x11, core=3 into an idle controller; cfg_valid_i 2 cycles after CONFIG entry; w_loaded_i after 3; z_done_i after 5.
  - required: cfg_start_o one cycle; first_load_o only in STARTING; one-cycle FINISHED with evt_o[3]=2'b01, done_id_o=0x11, done_err_o=0; busy_o falls the cycle after.
- Queue full:
  - stimulus: push 5 jobs back-to-back while the first is in CONFIG (N_JOBS=4).
  - required: job_ready_o=0 once pending_o=4, fifth push held until first retires; jobs retire in push order; 2-cycle gap between FINISHED and the next CONFIG.
- Watchdog:
  - stimulus: timeout_i=20, w_loaded_i never asserted.
  - required: ABORT 21 cycles after CONFIG entry; evt_o[core]=2'b10; done_err_o=1; finished_o=0; queue advances.
- Priority:
  - stimulus (a): z_done_i in the same cycle the timeout fires.
  - required (a): FINISHED, not ABORT.
  - stimulus (b): abort_i together with z_done_i.
  - required (b): ABORT.
  - stimulus (c): abort_i in IDLE.
  - required (c): ignored.
- Clear:
  - stimulus: clear_i while in COMPUTING with 3 jobs pending, plus a simultaneous push.
  - required: next cycle IDLE, pending_o=0, no event, busy_o=0, push dropped.
- Reset:
  - stimulus: assert rst_i asynchronously mid-STARTING.
  - required: outputs return to reset values immediately; job_ready_o=1 after release.
